// File: rtl/soc_system_done_pkg.sv
// Shared constants and helpers for the completion mailbox.
package soc_system_done_pkg;

    // Register offsets above the entry window (added to DEPTH).
    localparam int FLAGS_OFS = 0;
    localparam int MASK_OFS  = 1;
    localparam int OVR_OFS   = 2;

    // A port only acts on an access when it is clocked, not inhibited, and selected.
    function automatic logic port_active(input logic clken,
                                         input logic reset_req,
                                         input logic chipselect);
        return clken & ~reset_req & chipselect;
    endfunction

endpackage

// File: rtl/soc_system_done_mailbox_if.sv
// One Avalon-MM style mailbox port; the mailbox has two of these (s1 host, s2 producer).
interface soc_system_done_mailbox_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int ADDR_WIDTH = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  clken;
    logic                  reset_req;
    logic [DATA_WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata, clken, reset_req,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata, clken, reset_req,
        output readdata
    );
endinterface

// File: rtl/soc_system_done_mailbox_regfile.sv
// Entry storage: DEPTH words, s2 wins when both ports write the same entry.
// Reads are combinational here; the top registers them so a same-cycle
// write is never visible to the read (read-before-write).
module soc_system_done_mailbox_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we1,
    input  logic [IDX_W-1:0]      i_idx1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic                  i_we2,
    input  logic [IDX_W-1:0]      i_idx2,
    input  logic [DATA_WIDTH-1:0] i_wdata2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_mem;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] r_entry;

            // Per-entry write mux with producer priority.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_entry <= '0;
                end else if (i_we2 && (i_idx2 == IDX_W'(gi))) begin
                    r_entry <= i_wdata2;
                end else if (i_we1 && (i_idx1 == IDX_W'(gi))) begin
                    r_entry <= i_wdata1;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    assign o_rdata1 = w_mem[i_idx1];
    assign o_rdata2 = w_mem[i_idx2];
endmodule

// File: rtl/soc_system_done_mailbox.sv
// Two-port completion mailbox: sticky done flags set by the producer (s2),
// cleared by host reads/writes (s1), with overrun status and a masked irq.
module soc_system_done_mailbox
    import soc_system_done_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    soc_system_done_mailbox_if.slave s1,
    soc_system_done_mailbox_if.slave s2,
    output logic [DEPTH-1:0]        done_flags,
    output logic                    irq
);
    localparam int ADDR_WIDTH = $clog2(DEPTH) + 1;
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FLAGS = ADDR_WIDTH'(DEPTH + FLAGS_OFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ADDR_WIDTH'(DEPTH + MASK_OFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OVR   = ADDR_WIDTH'(DEPTH + OVR_OFS);

    logic                  w_s1_act, w_s1_rd, w_s1_wr;
    logic                  w_s2_act, w_s2_rd, w_s2_wr;
    logic                  w_s1_is_entry, w_s2_is_entry;
    logic [IDX_W-1:0]      w_s1_idx, w_s2_idx;
    logic [DATA_WIDTH-1:0] w_s1_mem, w_s2_mem;
    logic [DATA_WIDTH-1:0] w_s1_rdata_next, w_s2_rdata_next;
    logic [DEPTH-1:0]      w_flag_set, w_flag_clr, w_ovr_set, w_ovr_clr;

    logic [DEPTH-1:0]      r_flags, r_ovr;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_s1_rdata, r_s2_rdata;
    logic                  r_irq;

    assign w_s1_act = port_active(s1.clken, s1.reset_req, s1.chipselect);
    assign w_s2_act = port_active(s2.clken, s2.reset_req, s2.chipselect);
    assign w_s1_rd  = w_s1_act & s1.read;
    assign w_s1_wr  = w_s1_act & s1.write;
    assign w_s2_rd  = w_s2_act & s2.read;
    assign w_s2_wr  = w_s2_act & s2.write;

    // Entry window is the lower half of the address space.
    assign w_s1_is_entry = ~s1.address[ADDR_WIDTH-1];
    assign w_s2_is_entry = ~s2.address[ADDR_WIDTH-1];
    assign w_s1_idx      = s1.address[IDX_W-1:0];
    assign w_s2_idx      = s2.address[IDX_W-1:0];

    soc_system_done_mailbox_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (reset),
        .i_we1    (w_s1_wr & w_s1_is_entry),
        .i_idx1   (w_s1_idx),
        .i_wdata1 (s1.writedata),
        .i_we2    (w_s2_wr & w_s2_is_entry),
        .i_idx2   (w_s2_idx),
        .i_wdata2 (s2.writedata),
        .o_rdata1 (w_s1_mem),
        .o_rdata2 (w_s2_mem)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            assign w_flag_set[gi] = w_s2_wr & w_s2_is_entry & (w_s2_idx == IDX_W'(gi));
            assign w_flag_clr[gi] = ((w_s1_rd | w_s1_wr) & w_s1_is_entry & (w_s1_idx == IDX_W'(gi)))
                                  | (w_s1_wr & (s1.address == ADDR_FLAGS) & s1.writedata[gi]);
            assign w_ovr_set[gi]  = w_flag_set[gi] & r_flags[gi];
            assign w_ovr_clr[gi]  = w_s1_wr & (s1.address == ADDR_OVR) & s1.writedata[gi];
        end
    endgenerate

    // Flag/overrun/mask state; sets are applied after clears so sets win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
            r_ovr   <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
            r_ovr   <= (r_ovr & ~w_ovr_clr) | w_ovr_set;
            if (w_s1_wr && (s1.address == ADDR_MASK)) begin
                r_mask <= s1.writedata;
            end
            r_irq   <= |(r_flags & r_mask[DEPTH-1:0]);
        end
    end

    // Host read mux over entries and status registers.
    always_comb begin
        w_s1_rdata_next = '0;
        if (w_s1_is_entry) begin
            w_s1_rdata_next = w_s1_mem;
        end else if (s1.address == ADDR_FLAGS) begin
            w_s1_rdata_next = DATA_WIDTH'(r_flags);
        end else if (s1.address == ADDR_MASK) begin
            w_s1_rdata_next = r_mask;
        end else if (s1.address == ADDR_OVR) begin
            w_s1_rdata_next = DATA_WIDTH'(r_ovr);
        end
    end

    // Producer read mux: entries and FLAGS only.
    always_comb begin
        w_s2_rdata_next = '0;
        if (w_s2_is_entry) begin
            w_s2_rdata_next = w_s2_mem;
        end else if (s2.address == ADDR_FLAGS) begin
            w_s2_rdata_next = DATA_WIDTH'(r_flags);
        end
    end

    // Read data registers hold between accepted reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_rdata <= '0;
            r_s2_rdata <= '0;
        end else begin
            if (w_s1_rd) r_s1_rdata <= w_s1_rdata_next;
            if (w_s2_rd) r_s2_rdata <= w_s2_rdata_next;
        end
    end

    assign s1.readdata = r_s1_rdata;
    assign s2.readdata = r_s2_rdata;
    assign done_flags  = r_flags;
    assign irq         = r_irq;
endmodule

// File: tb/tb_soc_system_done_mailbox.sv
// Directed bench for the completion mailbox with a behavioural reference model.
module tb_soc_system_done_mailbox;
    localparam int DW = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DP-1:0] done_flags;
    logic irq;

    int checks = 0;
    int failures = 0;

    soc_system_done_mailbox_if #(.DATA_WIDTH(DW), .DEPTH(DP)) s1_if ();
    soc_system_done_mailbox_if #(.DATA_WIDTH(DW), .DEPTH(DP)) s2_if ();

    soc_system_done_mailbox #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .s1         (s1_if),
        .s2         (s2_if),
        .done_flags (done_flags),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_mem [DP];
    logic [3:0] m_flags = '0, m_ovr = '0, m_nf, m_no;
    logic [7:0] m_mask = '0, m_rd1 = '0, m_rd2 = '0;
    logic       m_irq = 1'b0;
    bit         m_a1, m_a2;
    int         m_i1, m_i2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the mailbox rules access by access at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DP; i++) m_mem[i] = 8'h00;
            m_flags = '0; m_ovr = '0; m_mask = '0; m_rd1 = '0; m_rd2 = '0; m_irq = 1'b0;
        end else begin
            m_a1 = s1_if.clken && !s1_if.reset_req && s1_if.chipselect;
            m_a2 = s2_if.clken && !s2_if.reset_req && s2_if.chipselect;
            m_i1 = int'(s1_if.address);
            m_i2 = int'(s2_if.address);
            m_nf = m_flags;
            m_no = m_ovr;
            m_irq = |(m_flags & m_mask[3:0]);
            if (m_a1 && s1_if.read) begin
                if (m_i1 < DP)          m_rd1 = m_mem[m_i1];
                else if (m_i1 == DP)    m_rd1 = {4'h0, m_flags};
                else if (m_i1 == DP+1)  m_rd1 = m_mask;
                else if (m_i1 == DP+2)  m_rd1 = {4'h0, m_ovr};
                else                    m_rd1 = 8'h00;
                if (m_i1 < DP) m_nf[m_i1] = 1'b0;
            end
            if (m_a2 && s2_if.read) begin
                if (m_i2 < DP)          m_rd2 = m_mem[m_i2];
                else if (m_i2 == DP)    m_rd2 = {4'h0, m_flags};
                else                    m_rd2 = 8'h00;
            end
            if (m_a1 && s1_if.write) begin
                if (m_i1 < DP) begin
                    m_mem[m_i1] = s1_if.writedata;
                    m_nf[m_i1] = 1'b0;
                end else if (m_i1 == DP)   m_nf = m_nf & ~s1_if.writedata[3:0];
                else if (m_i1 == DP+1)     m_mask = s1_if.writedata;
                else if (m_i1 == DP+2)     m_no = m_no & ~s1_if.writedata[3:0];
            end
            if (m_a2 && s2_if.write && m_i2 < DP) begin
                if (m_flags[m_i2]) m_no[m_i2] = 1'b1;
                m_nf[m_i2] = 1'b1;
                m_mem[m_i2] = s2_if.writedata;
            end
            m_flags = m_nf;
            m_ovr = m_no;
        end
    end

    // Compare all outputs against the model every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_readdata",  32'(s1_if.readdata), 32'(m_rd1));
            check("cyc_readdata2", 32'(s2_if.readdata), 32'(m_rd2));
            check("cyc_done_flags", 32'(done_flags), 32'(m_flags));
            check("cyc_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic step(input logic cs1, input logic r1, input logic w1,
                        input logic [2:0] a1, input logic [7:0] d1,
                        input logic cs2, input logic r2, input logic w2,
                        input logic [2:0] a2, input logic [7:0] d2);
        s1_if.chipselect = cs1; s1_if.read = r1; s1_if.write = w1;
        s1_if.address = a1; s1_if.writedata = d1;
        s2_if.chipselect = cs2; s2_if.read = r2; s2_if.write = w2;
        s2_if.address = a2; s2_if.writedata = d2;
        @(posedge clk); #2;
        s1_if.chipselect = 1'b0; s1_if.read = 1'b0; s1_if.write = 1'b0;
        s2_if.chipselect = 1'b0; s2_if.read = 1'b0; s2_if.write = 1'b0;
    endtask

    task automatic rd1(input logic [2:0] a);
        step(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask
    task automatic wr1(input logic [2:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask
    task automatic rd2(input logic [2:0] a);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, a, 8'h00);
    endtask
    task automatic wr2(input logic [2:0] a, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        s1_if.chipselect = 0; s1_if.read = 0; s1_if.write = 0; s1_if.address = '0;
        s1_if.writedata = '0; s1_if.clken = 1; s1_if.reset_req = 0;
        s2_if.chipselect = 0; s2_if.read = 0; s2_if.write = 0; s2_if.address = '0;
        s2_if.writedata = '0; s2_if.clken = 1; s2_if.reset_req = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state: every s1 address reads zero
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_flags", 32'(done_flags), 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd1(3'(a));
            check($sformatf("rst_read_addr%0d", a), 32'(s1_if.readdata), 32'h00);
        end

        // Done flag, FLAGS read and irq timing
        wr1(3'd5, 8'h04);
        wr2(3'd2, 8'hA5);
        check("irq_lag_low", 32'(irq), 32'h0);
        check("flag2_set", 32'(done_flags), 32'h4);
        rd1(3'd4);
        check("flags_read", 32'(s1_if.readdata), 32'h04);
        check("irq_high", 32'(irq), 32'h1);
        rd1(3'd2);
        check("entry2_read", 32'(s1_if.readdata), 32'hA5);
        check("irq_still_high", 32'(irq), 32'h1);
        rd1(3'd4);
        check("flags_cleared", 32'(s1_if.readdata), 32'h00);
        check("irq_fell", 32'(irq), 32'h0);

        // Overrun and its W1C
        wr2(3'd1, 8'h11);
        wr2(3'd1, 8'h22);
        rd1(3'd6);
        check("overrun_read", 32'(s1_if.readdata), 32'h02);
        rd1(3'd1);
        check("entry1_latest", 32'(s1_if.readdata), 32'h22);
        wr1(3'd6, 8'h02);
        rd1(3'd6);
        check("overrun_w1c", 32'(s1_if.readdata), 32'h00);

        // s1 read vs s2 write on the same entry
        wr2(3'd3, 8'h33);
        step(1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h44);
        check("rbw_old_data", 32'(s1_if.readdata), 32'h33);
        check("rbw_flag3_set", 32'(done_flags[3]), 32'h1);
        rd1(3'd3);
        check("rbw_new_data", 32'(s1_if.readdata), 32'h44);

        // Both ports write entry 0
        step(1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 3'd0, 8'h02);
        check("ww_flag0", 32'(done_flags[0]), 32'h1);
        rd1(3'd0);
        check("ww_s2_wins", 32'(s1_if.readdata), 32'h02);

        // Inactive port: clken low, then reset_req high
        wr2(3'd2, 8'h5A);
        rd2(3'd2);
        check("s2_entry_read", 32'(s2_if.readdata), 32'h5A);
        rd2(3'd4);
        check("s2_flags_read", 32'(s2_if.readdata), 32'h04);
        rd1(3'd7);
        check("unmapped_read", 32'(s1_if.readdata), 32'h00);
        s1_if.clken = 1'b0;
        rd1(3'd2);
        check("clken_hold_data", 32'(s1_if.readdata), 32'h00);
        check("clken_flag_kept", 32'(done_flags[2]), 32'h1);
        s1_if.clken = 1'b1;
        s1_if.reset_req = 1'b1;
        rd1(3'd2);
        check("rreq_hold_data", 32'(s1_if.readdata), 32'h00);
        check("rreq_flag_kept", 32'(done_flags[2]), 32'h1);
        s1_if.reset_req = 1'b0;
        rd1(3'd2);
        check("active_read", 32'(s1_if.readdata), 32'h5A);

        // Reset in the middle of a write burst
        wr1(3'd5, 8'h0F);
        wr2(3'd1, 8'h77);
        s2_if.chipselect = 1'b1; s2_if.write = 1'b1; s2_if.address = 3'd2; s2_if.writedata = 8'h99;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        s2_if.chipselect = 1'b0; s2_if.write = 1'b0;
        check("midrst_flags", 32'(done_flags), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_readdata", 32'(s1_if.readdata), 32'h00);
        rd1(3'd2);
        check("midrst_entry2", 32'(s1_if.readdata), 32'h00);
        rd1(3'd5);
        check("midrst_mask", 32'(s1_if.readdata), 32'h00);

        @(posedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
